// File: rtl/wave_gen.sv
// Eight-step waveform generator: sine, square, triangle or sawtooth, each step held for hold_period+1 clocks.
// Optional output attenuation is compiled in with the WAVE_GEN_AMP_SHIFT_EN macro (adds the amp_shift input).
module wave_gen #(
  parameter int DATA_W = 16,
  parameter int HOLD_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [HOLD_W-1:0] hold_period,
`ifdef WAVE_GEN_AMP_SHIFT_EN
  input  logic [3:0]        amp_shift,
`endif
  output logic [DATA_W-1:0] wave_data,
  output logic              wave_valid,
  output logic [2:0]        step_idx,
  output logic              step_strobe,
  output logic              cycle_done
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [2:0]        step_q, step_d;
  logic [1:0]        mode_q, mode_d;
  logic [3:0]        shift_q, shift_d;
  logic              strobe_q, strobe_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [3:0]        shift_in;
  logic              step_end;

`ifdef WAVE_GEN_AMP_SHIFT_EN
  assign shift_in = amp_shift;
`else
  assign shift_in = 4'd0;
`endif

  function automatic logic [15:0] table_lookup(input logic [1:0] m, input logic [2:0] s);
    logic [15:0] v;
    v = 16'h0000;
    case (m)
      2'd0: begin
        case (s)
          3'd0: v = 16'h0000;
          3'd1: v = 16'h5A7E;
          3'd2: v = 16'h7FFF;
          3'd3: v = 16'h5A7E;
          3'd4: v = 16'h0000;
          3'd5: v = 16'hA582;
          3'd6: v = 16'h8000;
          default: v = 16'hA582;
        endcase
      end
      2'd1: v = s[2] ? 16'h8000 : 16'h7FFF;
      2'd2: begin
        case (s)
          3'd0: v = 16'h0000;
          3'd1: v = 16'h4000;
          3'd2: v = 16'h7FFF;
          3'd3: v = 16'h4000;
          3'd4: v = 16'h0000;
          3'd5: v = 16'hC000;
          3'd6: v = 16'h8000;
          default: v = 16'hC000;
        endcase
      end
      default: v = {~s[2], s[1:0], 13'd0};  // sawtooth: 8000 + s*2000, wrapping at step 4
    endcase
    return v;
  endfunction

  // Keep the top DATA_W bits, then attenuate with sign fill; shifts past the width leave only sign bits.
  function automatic logic [DATA_W-1:0] scale_sample(input logic [15:0] raw, input logic [3:0] sh);
    logic signed [DATA_W-1:0] trunc;
    trunc = $signed(raw[15 -: DATA_W]);
    if (int'(sh) >= DATA_W) begin
      return {DATA_W{trunc[DATA_W-1]}};
    end
    return trunc >>> sh;
  endfunction

  assign step_end = (cnt_q == hold_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hold_q   <= '0;
      step_q   <= 3'd0;
      mode_q   <= 2'd0;
      shift_q  <= 4'd0;
      strobe_q <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      step_q   <= step_d;
      mode_q   <= mode_d;
      shift_q  <= shift_d;
      strobe_q <= strobe_d;
      data_q   <= data_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    step_d   = step_q;
    mode_d   = mode_q;
    shift_d  = shift_q;
    strobe_d = 1'b0;
    data_d   = data_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        step_d = 3'd0;
        data_d = '0;
        if (en) begin
          state_d  = ST_RUN;
          mode_d   = mode;
          hold_d   = hold_period;
          shift_d  = shift_in;
          strobe_d = 1'b1;
          data_d   = scale_sample(table_lookup(mode, 3'd0), shift_in);
        end
      end
      default: begin
        if (!en) begin
          // Dropping enable beats any pending step or wrap on this edge.
          state_d = ST_IDLE;
          cnt_d   = '0;
          step_d  = 3'd0;
          data_d  = '0;
        end else if (step_end) begin
          cnt_d    = '0;
          step_d   = step_q + 3'd1;
          strobe_d = 1'b1;
          if (step_q == 3'd7) begin
            mode_d  = mode;
            hold_d  = hold_period;
            shift_d = shift_in;
          end
          data_d = scale_sample(table_lookup(mode_d, step_d), shift_d);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  assign wave_data   = data_q;
  assign wave_valid  = (state_q == ST_RUN);
  assign step_idx    = step_q;
  assign step_strobe = strobe_q;
  assign cycle_done  = (state_q == ST_RUN) && (step_q == 3'd7) && step_end;

endmodule
